alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter ALU_LAT, default 1, cycles from ALU input issue to valid alu_result (legal 1-4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has a command pending.
REQ-005 req0_ready, req1_ready  output  1 each  command accepted when valid&&ready at a rising edge.
REQ-006 req0_opcode, req1_opcode  input  3 each  ALU opcode (000 PASSA, 001 ADD, 010 SUB, 011 AND, 100 XOR, 101 ABS, 110 CAL, 111 CND).
REQ-007 req0_data, req1_data  input  8 each  operand for the ALU data port.
REQ-008 req0_load, req1_load  input  1 each  1 = load own accumulator with data, bypass ALU.
REQ-009 alu_opcode  output  3, alu_data  output  8, alu_accum  output  8  drive the shared ALU.
REQ-010 alu_result  input  8, alu_zero  input  1  ALU alu_out and zero.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_id  output  1  requester that owns the response.
REQ-013 rsp_result  output  8, rsp_zero  output  1  captured result and zero flag.
REQ-014 acc0, acc1  output  8 each  per-requester accumulator contents.

Function
REQ-015 Block SHALL keep one 8-bit accumulator per requester; the ALU accum port SHALL always carry the owner's accumulator.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: ready SHALL be asserted only to the granted requester, combinationally from valid and priority pointer; never both readys high.
REQ-018 Arbitration SHALL be round-robin: pointer favours req0 after reset and flips to the non-granted requester after each acceptance; a lone valid requester is granted regardless of pointer.
REQ-019 On acceptance in cycle T, opcode, data, load and id SHALL be registered; ALU op -> ISSUE in T+1; load op -> DONE in T+1.
REQ-020 ISSUE (T+1): alu_opcode/alu_data/alu_accum SHALL be driven from registers and held stable until DONE; alu_zero SHALL be sampled at end of ISSUE.
REQ-021 WAIT: a counter SHALL hold for ALU_LAT-1 cycles beyond ISSUE; alu_result SHALL be sampled at the edge ending cycle T+1+ALU_LAT.
REQ-022 DONE (T+2+ALU_LAT for ALU ops, T+1 for loads): rsp_valid=1 for exactly one cycle, rsp_id/rsp_result/rsp_zero valid that cycle; owner accumulator SHALL show the new value in the same cycle.
REQ-023 Load op: rsp_result=data, rsp_zero=(old accumulator==0), accumulator=data.
REQ-024 DONE SHALL return to IDLE next cycle; no command accepted outside IDLE; throughput one ALU op per ALU_LAT+3 cycles.
REQ-025 Idle ALU outputs SHALL be opcode 000, data 00, accum 00.
REQ-026 Arithmetic is 8-bit modulo; result truncation is the ALU's, controller SHALL not alter it.
REQ-027 Requester changing inputs while not accepted SHALL have no effect; deasserting valid before acceptance withdraws the command.

Reset
REQ-028 Reset high at a rising edge SHALL force IDLE, pointer=req0, acc0=acc1=00, rsp_valid=0, rsp_id=0, rsp_result=00, rsp_zero=0, ALU outputs per REQ-025, readys 0 during reset.
REQ-029 Reset during ISSUE/WAIT/DONE SHALL abort the operation: no rsp_valid, no accumulator write.

Verification
REQ-030 After reset, req0 load data 37 -> rsp_valid at T+1, rsp_id 0, rsp_result 37, rsp_zero 1, acc0=37, acc1=00.
REQ-031 acc0=37, req0 ADD data D6, ALU_LAT=1 -> alu_accum 37, alu_data D6 held T+1..T+3; rsp_valid at T+3, rsp_result 0D, rsp_zero 0, acc0=0D.
REQ-032 Both valid continuously from reset with ADD data 01 -> grants alternate 0,1,0,1; acc0 and acc1 each increment by 1 per own response; no back-to-back responses closer than 4 cycles.
REQ-033 acc1=00, req1 CAL data 00 -> rsp_zero 1, rsp_result 00; then req1 load 40, CND data 0F -> rsp_result 0F, acc1=0F.
REQ-034 Reset asserted during WAIT of req0 SUB -> no rsp_valid, acc0=00, ready returns in first IDLE cycle after reset release.
REQ-035 ALU_LAT=3, req0 XOR with acc0=FF data 0F -> rsp_valid exactly at T+5, rsp_result F0.

Source files
------------

// File: rtl/alu_sched_if.sv
// -----------------------------------------------------------------------------
// alu_sched_if -- bundle of every non-clock signal around alu_sched.
//
// Groups:
//   req0_* / req1_*  two requesters: valid, ready, opcode[2:0], data[7:0], load
//   alu_*            shared ALU: opcode/data/accum toward the ALU,
//                    result/zero back from it
//   rsp_*            completion pulse with owner id, result and zero flag
//   acc0 / acc1      per-requester accumulator contents
//
// Modports:
//   slave  -- the scheduler (accepts requests, drives the ALU, reports results)
//   master -- the environment (requesters plus the ALU itself)
// -----------------------------------------------------------------------------
interface alu_sched_if;

  // Requester 0
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_opcode;
  logic [7:0] req0_data;
  logic       req0_load;

  // Requester 1
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_opcode;
  logic [7:0] req1_data;
  logic       req1_load;

  // Shared ALU
  logic [2:0] alu_opcode;
  logic [7:0] alu_data;
  logic [7:0] alu_accum;
  logic [7:0] alu_result;
  logic       alu_zero;

  // Completion
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_zero;

  // Accumulators
  logic [7:0] acc0;
  logic [7:0] acc1;

  modport slave (
    input  req0_valid, req0_opcode, req0_data, req0_load,
    input  req1_valid, req1_opcode, req1_data, req1_load,
    output req0_ready, req1_ready,
    output alu_opcode, alu_data, alu_accum,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    output acc0, acc1
  );

  modport master (
    output req0_valid, req0_opcode, req0_data, req0_load,
    output req1_valid, req1_opcode, req1_data, req1_load,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_data, alu_accum,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  acc0, acc1
  );

endinterface : alu_sched_if

// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched -- two-requester scheduler for one shared, pipelined ALU.
//
// Each requester owns an 8-bit accumulator. A round-robin arbiter accepts one
// command at a time. ALU commands present {opcode, data, owner accumulator}
// to the ALU from ISSUE through DONE, sample alu_zero at the end of ISSUE and
// alu_result ALU_LAT cycles later, then write the result back to the owner
// accumulator and pulse rsp_valid. Load commands bypass the ALU and complete
// in the cycle after acceptance.
//
// Parameters:
//   ALU_LAT  cycles from ALU input issue to valid alu_result (1..4)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    alu_sched_if.slave (requests, ALU drive/return, response, accs)
// -----------------------------------------------------------------------------
module alu_sched #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_sched_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter guard
  // ---------------------------------------------------------------------------
  if (ALU_LAT < 1 || ALU_LAT > 4) begin : g_bad_lat
    $error("alu_sched: ALU_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // WAIT lasts ALU_LAT cycles; the counter runs 0 .. WAIT_LAST.
  localparam logic [1:0] WAIT_LAST = 2'(ALU_LAT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e     state_q,  state_d;
  logic       ptr_q,    ptr_d;     // round-robin favourite: 0 = req0
  logic       id_q,     id_d;      // owner of the command in flight
  logic [2:0] op_q,     op_d;
  logic [7:0] data_q,   data_d;
  logic       load_q,   load_d;
  logic [7:0] accum_q,  accum_d;   // owner accumulator snapshot fed to the ALU
  logic [1:0] cnt_q,    cnt_d;
  logic [7:0] acc0_q,   acc0_d;
  logic [7:0] acc1_q,   acc1_d;
  logic [7:0] result_q, result_d;
  logic       zero_q,   zero_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic       grant_any;
  logic       grant_id;
  logic       accept;
  logic [2:0] sel_op;
  logic [7:0] sel_data;
  logic       sel_load;
  logic [7:0] sel_acc;

  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    // Pointer only matters on contention; a lone requester always wins.
    grant_id  = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
    accept    = (state_q == IDLE) & grant_any & ~reset;
    sel_op    = grant_id ? bus.req1_opcode : bus.req0_opcode;
    sel_data  = grant_id ? bus.req1_data   : bus.req0_data;
    sel_load  = grant_id ? bus.req1_load   : bus.req0_load;
    sel_acc   = grant_id ? acc1_q          : acc0_q;
  end

  assign bus.req0_ready = accept & ~grant_id;
  assign bus.req1_ready = accept &  grant_id;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    data_d   = data_q;
    load_d   = load_q;
    accum_d  = accum_q;
    cnt_d    = cnt_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = grant_id;
          op_d    = sel_op;
          data_d  = sel_data;
          load_d  = sel_load;
          accum_d = sel_acc;
          ptr_d   = ~grant_id;
          if (sel_load) begin
            // Load completes next cycle: response and accumulator update are
            // registered together so both appear in DONE.
            result_d = sel_data;
            zero_d   = (sel_acc == 8'h00);
            if (grant_id) acc1_d = sel_data;
            else          acc0_d = sel_data;
            state_d  = DONE;
          end else begin
            state_d  = ISSUE;
          end
        end
      end

      ISSUE: begin
        zero_d  = bus.alu_zero;
        cnt_d   = 2'd0;
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          // Result is taken verbatim; truncation is the ALU's business.
          result_d = bus.alu_result;
          if (id_q) acc1_d = bus.alu_result;
          else      acc0_d = bus.alu_result;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every flop samples the values from
  // before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= 3'd0;
      data_q   <= 8'h00;
      load_q   <= 1'b0;
      accum_q  <= 8'h00;
      cnt_q    <= 2'd0;
      acc0_q   <= 8'h00;
      acc1_q   <= 8'h00;
      result_q <= 8'h00;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      data_q   <= data_d;
      load_q   <= load_d;
      accum_q  <= accum_d;
      cnt_q    <= cnt_d;
      acc0_q   <= acc0_d;
      acc1_q   <= acc1_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // ALU inputs stay stable from ISSUE through DONE of an ALU command; a load
  // never touches the ALU, so its DONE cycle shows the idle pattern.
  logic alu_drive;

  always_comb begin
    alu_drive = (state_q == ISSUE) | (state_q == WAIT) |
                ((state_q == DONE) & ~load_q);
  end

  assign bus.alu_opcode = alu_drive ? op_q    : 3'd0;
  assign bus.alu_data   = alu_drive ? data_q  : 8'h00;
  assign bus.alu_accum  = alu_drive ? accum_q : 8'h00;

  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;

  assign bus.acc0       = acc0_q;
  assign bus.acc1       = acc1_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_one_ready : assert property (@(posedge clk) disable iff (reset)
    !(bus.req0_ready && bus.req1_ready));

  a_done_pulse : assert property (@(posedge clk) disable iff (reset)
    (state_q == DONE) |=> (state_q == IDLE));

endmodule : alu_sched

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched -- directed bench for alu_sched.
//
// Two instances share clk/reset: u_dut1 (ALU_LAT=1) and u_dut3 (ALU_LAT=3).
// Requester stimulus is steered to one of them by use3; observed outputs are
// muxed back the same way so one set of tasks serves both. Each instance has
// its own reference ALU: combinational zero, result delayed ALU_LAT cycles.
// Reference ALU: PASSA=a, ADD=a+d, SUB=a-d, AND, XOR, ABS=|d|, CAL=a+d,
// CND = (a!=0) ? d : a, with a = alu_accum and d = alu_data.
// -----------------------------------------------------------------------------
module tb_alu_sched;

  localparam logic [2:0] OP_PASSA = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2,
                         OP_AND   = 3'd3, OP_XOR = 3'd4, OP_ABS = 3'd5,
                         OP_CAL   = 3'd6, OP_CND = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic use3 = 1'b0;

  always #5 clk = ~clk;

  // Requester drive
  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic [2:0] r0_op = 3'd0, r1_op = 3'd0;
  logic [7:0] r0_data = 8'h00, r1_data = 8'h00;
  logic       r0_load = 1'b0, r1_load = 1'b0;

  alu_sched_if bus1 ();
  alu_sched_if bus3 ();

  alu_sched #(.ALU_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  alu_sched #(.ALU_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  assign bus1.req0_valid  = r0_valid & ~use3;
  assign bus1.req1_valid  = r1_valid & ~use3;
  assign bus3.req0_valid  = r0_valid &  use3;
  assign bus3.req1_valid  = r1_valid &  use3;
  assign bus1.req0_opcode = r0_op;   assign bus3.req0_opcode = r0_op;
  assign bus1.req1_opcode = r1_op;   assign bus3.req1_opcode = r1_op;
  assign bus1.req0_data   = r0_data; assign bus3.req0_data   = r0_data;
  assign bus1.req1_data   = r1_data; assign bus3.req1_data   = r1_data;
  assign bus1.req0_load   = r0_load; assign bus3.req0_load   = r0_load;
  assign bus1.req1_load   = r1_load; assign bus3.req1_load   = r1_load;

  // Reference ALUs
  function automatic logic [7:0] alu_fn(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] d);
    logic [7:0] r;
    case (op)
      OP_PASSA: r = a;
      OP_ADD:   r = a + d;
      OP_SUB:   r = a - d;
      OP_AND:   r = a & d;
      OP_XOR:   r = a ^ d;
      OP_ABS:   r = d[7] ? 8'(8'h00 - d) : d;
      OP_CAL:   r = a + d;
      default:  r = (a != 8'h00) ? d : a;
    endcase
    return r;
  endfunction

  logic [7:0] p1;
  logic [7:0] p3 [3];

  always @(posedge clk) begin
    p1    <= alu_fn(bus1.alu_opcode, bus1.alu_accum, bus1.alu_data);
    p3[0] <= alu_fn(bus3.alu_opcode, bus3.alu_accum, bus3.alu_data);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign bus1.alu_result = p1;
  assign bus1.alu_zero   = (alu_fn(bus1.alu_opcode, bus1.alu_accum, bus1.alu_data) == 8'h00);
  assign bus3.alu_result = p3[2];
  assign bus3.alu_zero   = (alu_fn(bus3.alu_opcode, bus3.alu_accum, bus3.alu_data) == 8'h00);

  // Observed outputs of the selected instance
  wire       o_ready0   = use3 ? bus3.req0_ready : bus1.req0_ready;
  wire       o_ready1   = use3 ? bus3.req1_ready : bus1.req1_ready;
  wire       o_rsp_v    = use3 ? bus3.rsp_valid  : bus1.rsp_valid;
  wire       o_rsp_id   = use3 ? bus3.rsp_id     : bus1.rsp_id;
  wire [7:0] o_rsp_res  = use3 ? bus3.rsp_result : bus1.rsp_result;
  wire       o_rsp_z    = use3 ? bus3.rsp_zero   : bus1.rsp_zero;
  wire [7:0] o_acc0     = use3 ? bus3.acc0       : bus1.acc0;
  wire [7:0] o_acc1     = use3 ? bus3.acc1       : bus1.acc1;
  wire [2:0] o_alu_op   = use3 ? bus3.alu_opcode : bus1.alu_opcode;
  wire [7:0] o_alu_data = use3 ? bus3.alu_data   : bus1.alu_data;
  wire [7:0] o_alu_acc  = use3 ? bus3.alu_accum  : bus1.alu_accum;

  // Checking
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle_alu(input string tag);
    check({tag, ".idle_op"},    32'(o_alu_op),   32'h0);
    check({tag, ".idle_data"},  32'(o_alu_data), 32'h0);
    check({tag, ".idle_accum"}, 32'(o_alu_acc),  32'h0);
  endtask

  // Issue one command from requester id, wait for its response and check it.
  // exp_lat counts cycles from acceptance cycle T to the response cycle.
  task automatic send(input string tag, input logic id, input logic [2:0] op,
                      input logic [7:0] d, input logic ld, input int exp_lat,
                      input logic [7:0] exp_res, input logic exp_z,
                      input logic [7:0] acc_in);
    int n;
    @(negedge clk);
    if (id) begin r1_op = op; r1_data = d; r1_load = ld; r1_valid = 1'b1; end
    else    begin r0_op = op; r0_data = d; r0_load = ld; r0_valid = 1'b1; end
    #1;
    check({tag, ".ready"}, 32'(id ? o_ready1 : o_ready0), 32'h1);
    @(negedge clk);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    n = 1;
    while (!o_rsp_v && n < 12) begin
      if (!ld) begin
        check({tag, ".alu_op"},    32'(o_alu_op),   32'(op));
        check({tag, ".alu_data"},  32'(o_alu_data), 32'(d));
        check({tag, ".alu_accum"}, 32'(o_alu_acc),  32'(acc_in));
      end
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check({tag, ".rsp_id"},  32'(o_rsp_id),  32'(id));
    check({tag, ".result"},  32'(o_rsp_res), 32'(exp_res));
    check({tag, ".zero"},    32'(o_rsp_z),   32'(exp_z));
    check({tag, ".acc"},     32'(id ? o_acc1 : o_acc0), 32'(exp_res));
    if (!ld) check({tag, ".alu_accum_done"}, 32'(o_alu_acc), 32'(acc_in));
    @(negedge clk);
    check({tag, ".pulse_end"}, 32'(o_rsp_v), 32'h0);
    check_idle_alu(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen [2];
    int last_c;
    int nrsp;
    logic exp_id;
    logic both;
    logic stray;

    // ---- Reset state (valids high must not see ready) ----
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst.ready0", 32'(o_ready0), 32'h0);
    check("rst.ready1", 32'(o_ready1), 32'h0);
    check("rst.rsp_valid", 32'(o_rsp_v), 32'h0);
    check("rst.rsp_id", 32'(o_rsp_id), 32'h0);
    check("rst.rsp_result", 32'(o_rsp_res), 32'h0);
    check("rst.rsp_zero", 32'(o_rsp_z), 32'h0);
    check("rst.acc0", 32'(o_acc0), 32'h0);
    check("rst.acc1", 32'(o_acc1), 32'h0);
    check_idle_alu("rst");
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    reset = 1'b0;

    // ---- Load, then ADD with wrap, then remaining opcodes on req0 ----
    send("load37", 1'b0, OP_PASSA, 8'h37, 1'b1, 1, 8'h37, 1'b1, 8'h00);
    check("load37.acc1", 32'(o_acc1), 32'h0);
    send("addD6",  1'b0, OP_ADD,   8'hD6, 1'b0, 3, 8'h0D, 1'b0, 8'h37);
    send("sub0E",  1'b0, OP_SUB,   8'h0E, 1'b0, 3, 8'hFF, 1'b0, 8'h0D);
    send("passa",  1'b0, OP_PASSA, 8'h55, 1'b0, 3, 8'hFF, 1'b0, 8'hFF);
    send("and3C",  1'b0, OP_AND,   8'h3C, 1'b0, 3, 8'h3C, 1'b0, 8'hFF);
    send("absC4",  1'b0, OP_ABS,   8'hC4, 1'b0, 3, 8'h3C, 1'b0, 8'h3C);
    send("xor3C",  1'b0, OP_XOR,   8'h3C, 1'b0, 3, 8'h00, 1'b1, 8'h3C);
    check("req0ops.acc1", 32'(o_acc1), 32'h0);

    // ---- req1: CAL zero, load over zero accumulator, CND ----
    send("cal00",  1'b1, OP_CAL,   8'h00, 1'b0, 3, 8'h00, 1'b1, 8'h00);
    send("load40", 1'b1, OP_PASSA, 8'h40, 1'b1, 1, 8'h40, 1'b1, 8'h00);
    send("cnd0F",  1'b1, OP_CND,   8'h0F, 1'b0, 3, 8'h0F, 1'b0, 8'h40);
    check("req1ops.acc0", 32'(o_acc0), 32'h0);

    // ---- Round robin: both valid continuously from reset ----
    r0_op = OP_ADD; r0_data = 8'h01; r0_load = 1'b0; r0_valid = 1'b1;
    r1_op = OP_ADD; r1_data = 8'h01; r1_load = 1'b0; r1_valid = 1'b1;
    reset_dut();
    seen[0] = 0; seen[1] = 0;
    nrsp = 0; last_c = -100; exp_id = 1'b0; both = 1'b0;
    for (int c = 0; c < 60 && nrsp < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (o_ready0 && o_ready1) both = 1'b1;
      if (o_rsp_v) begin
        check("rr.id", 32'(o_rsp_id), 32'(exp_id));
        seen[exp_id]++;
        check("rr.acc", 32'(exp_id ? o_acc1 : o_acc0), 32'(seen[exp_id]));
        if (nrsp > 0) check("rr.spacing", 32'(c - last_c), 32'd4);
        last_c = c;
        nrsp++;
        exp_id = ~exp_id;
      end
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    check("rr.count", 32'(nrsp), 32'd6);
    check("rr.both_ready", 32'(both), 32'h0);

    // ---- Reset during WAIT aborts the SUB ----
    reset_dut();
    @(negedge clk);
    r0_op = OP_SUB; r0_data = 8'h05; r0_load = 1'b0; r0_valid = 1'b1;
    #1;
    check("abort.ready", 32'(o_ready0), 32'h1);
    @(negedge clk);                         // T+1, ISSUE
    r0_valid = 1'b0;
    check("abort.issue_rsp", 32'(o_rsp_v), 32'h0);
    @(negedge clk);                         // T+2, WAIT
    check("abort.wait_op", 32'(o_alu_op), 32'(OP_SUB));
    reset = 1'b1;
    r0_valid = 1'b1;
    @(negedge clk);
    #1;
    check("abort.rst_rsp", 32'(o_rsp_v), 32'h0);
    check("abort.rst_ready", 32'(o_ready0), 32'h0);
    reset = 1'b0;
    #1;
    check("abort.ready_back", 32'(o_ready0), 32'h1);
    check("abort.acc0", 32'(o_acc0), 32'h0);
    r0_valid = 1'b0;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_rsp_v) stray = 1'b1;
    end
    check("abort.no_rsp", 32'(stray), 32'h0);
    check("abort.acc0_after", 32'(o_acc0), 32'h0);

    // ---- ALU_LAT=3 instance: XOR FF^0F at T+5 ----
    use3 = 1'b1;
    reset_dut();
    send("l3.loadFF", 1'b0, OP_PASSA, 8'hFF, 1'b1, 1, 8'hFF, 1'b1, 8'h00);
    send("l3.xor0F",  1'b0, OP_XOR,   8'h0F, 1'b0, 5, 8'hF0, 1'b0, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_alu_sched
